// File: rtl/muldiv_seq_32.sv
// Iterative 32-bit multiply/divide unit (MULTU, MULT, DIVU, DIV), fixed 33-edge latency.
// Optional MULDIV_LO_ZERO_EN builds a registered lo==0 flag written alongside lo.
module muldiv_seq_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             lo_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mag_a_q, mag_a_d;
  logic [WIDTH-1:0]     mag_b_q, mag_b_d;
  logic [WIDTH-1:0]     a_raw_q, a_raw_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_sh;
  logic                 rem_ge;
  logic [WIDTH-1:0]     rem_new;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  // state register; rst outranks start and any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    mag_a_q   <= mag_a_d;
    mag_b_q   <= mag_b_d;
    a_raw_q   <= a_raw_d;
    is_div_q  <= is_div_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  // one iteration per CALC edge: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, mag_b_q});
    rem_new  = rem_ge ? WIDTH'(rem_sh - {1'b0, mag_b_q}) : rem_sh[WIDTH-1:0];
    prod_fix = neg_2w(acc_q, neg_res_q);
    quo_fix  = neg_w(acc_q[WIDTH-1:0], neg_res_q);
    rem_fix  = neg_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d  = op[1];
          neg_res_d = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = op[0] & a[WIDTH-1];
          mag_a_d   = neg_w(a, op[0] & a[WIDTH-1]);
          mag_b_d   = neg_w(b, op[0] & b[WIDTH-1]);
          a_raw_d   = a;
          cnt_d     = '0;
          acc_d     = op[1] ? {{WIDTH{1'b0}}, neg_w(a, op[0] & a[WIDTH-1])}
                            : {{WIDTH{1'b0}}, neg_w(b, op[0] & b[WIDTH-1])};
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = is_div_q ? {rem_new, acc_q[WIDTH-2:0], rem_ge}
                         : {mul_sum, acc_q[WIDTH-1:1]};
      end
      FIX: begin
        done_d = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (mag_b_q == '0) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: ;
    endcase
  end

`ifdef MULDIV_LO_ZERO_EN
  logic lo_zero_q, lo_zero_d;

  always_comb begin
    lo_zero_d = lo_zero_q;
    if (state_q == FIX) lo_zero_d = (lo_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) lo_zero_q <= 1'b0;
    else     lo_zero_q <= lo_zero_d;
  end

  assign lo_zero = lo_zero_q;
`else
  assign lo_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_seq_32.sv
// Directed bench for muldiv_seq_32: latency, signed/unsigned results, divide edge cases,
// start-while-busy, and mid-operation reset. lo_zero expectations follow MULDIV_LO_ZERO_EN.
module tb_muldiv_seq_32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, lo_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_LO_ZERO_EN
  localparam logic LZ_ON = 1'b1;
`else
  localparam logic LZ_ON = 1'b0;
`endif

  muldiv_seq_32 dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .lo_zero(lo_zero)
  );

  always #5 clk = ~clk;

  // Issue one op and wait (bounded) for done; returns edges from accept to done and busy cycles.
  task automatic run_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        output int lat, output int bcnt, output logic got);
    @(negedge clk);
    op = o; a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678;
    lat = 0; bcnt = 0; got = 1'b0;
    while (lat < 60 && !got) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, lo_zero} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b lo_zero=%b hi=%h lo=%h, required all zero",
               busy, done, lo_zero, hi, lo);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_multu_latency;
    int lat, bcnt; logic got;
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt, got);
    checks++;
    if (!got || lat !== 33) begin
      errors++; $display("FAIL multu_latency: got=%b lat=%0d, required 33", got, lat);
    end
    checks++;
    if (bcnt !== 33 || busy !== 1'b0) begin
      errors++; $display("FAIL multu_busy: busy cycles=%0d busy_at_done=%b, required 33/0", bcnt, busy);
    end
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      errors++; $display("FAIL multu_result: hi=%h lo=%h, required fffffffe/00000001", hi, lo);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || hi !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL done_pulse: done=%b hi=%h, required 0/fffffffe", done, hi);
    end
  endtask

  task automatic test_signed;
    int lat, bcnt; logic got;
    run_op(2'b01, 32'hFFFFFFFD, 32'd5, lat, bcnt, got);
    checks++;
    if (!got || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      errors++; $display("FAIL mult_neg: got=%b hi=%h lo=%h, required ffffffff/fffffff1", got, hi, lo);
    end
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, lat, bcnt, got);
    checks++;
    if (!got || lat !== 33 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div_neg: got=%b lat=%0d hi=%h lo=%h, required 33 ffffffff/fffffffd",
                         got, lat, hi, lo);
    end
  endtask

  task automatic test_div_edges;
    int lat, bcnt; logic got;
    run_op(2'b10, 32'd100, 32'd0, lat, bcnt, got);
    checks++;
    if (!got || lat !== 33 || hi !== 32'h00000064 || lo !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL divu_by_zero: got=%b lat=%0d hi=%h lo=%h, required 33 00000064/ffffffff",
                         got, lat, hi, lo);
    end
    run_op(2'b11, 32'hFFFFFFF0, 32'd0, lat, bcnt, got);
    checks++;
    if (!got || hi !== 32'hFFFFFFF0 || lo !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL div_by_zero: hi=%h lo=%h, required fffffff0/ffffffff", hi, lo);
    end
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, lat, bcnt, got);
    checks++;
    if (!got || hi !== 32'h0 || lo !== 32'h80000000) begin
      errors++; $display("FAIL div_min_neg1: hi=%h lo=%h, required 00000000/80000000", hi, lo);
    end
  endtask

  task automatic test_lo_zero;
    int lat, bcnt; logic got;
    run_op(2'b10, 32'd3, 32'd7, lat, bcnt, got);
    checks++;
    if (!got || hi !== 32'd3 || lo !== 32'd0 || lo_zero !== LZ_ON) begin
      errors++; $display("FAIL divu_small: hi=%h lo=%h lo_zero=%b, required 00000003/00000000/%b",
                         hi, lo, lo_zero, LZ_ON);
    end
    run_op(2'b00, 32'd2, 32'd3, lat, bcnt, got);
    checks++;
    if (!got || hi !== 32'd0 || lo !== 32'd6 || lo_zero !== 1'b0) begin
      errors++; $display("FAIL multu_2x3: hi=%h lo=%h lo_zero=%b, required 0/6/0", hi, lo, lo_zero);
    end
    run_op(2'b01, 32'd0, 32'hFFFFFFFF, lat, bcnt, got);
    checks++;
    if (!got || hi !== 32'd0 || lo !== 32'd0 || lo_zero !== LZ_ON) begin
      errors++; $display("FAIL mult_zero: hi=%h lo=%h lo_zero=%b, required 0/0/%b", hi, lo, lo_zero, LZ_ON);
    end
  endtask

  task automatic test_start_while_busy;
    int n; int dones; logic stable;
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo; stable = 1'b1;
    @(negedge clk);
    op = 2'b00; a = 32'd1000; b = 32'd1000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
      if (hi !== hi0 || lo !== lo0) stable = 1'b0;
    end
    @(negedge clk);
    op = 2'b10; a = 32'd77; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 10;
    while (n < 60 && !done) begin
      if (hi !== hi0 || lo !== lo0) stable = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 33 || hi !== 32'd0 || lo !== 32'd1000000) begin
      errors++; $display("FAIL start_ignored: done_edge=%0d hi=%h lo=%h, required 33 0/000f4240", n, hi, lo);
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL hold_while_busy: hi/lo changed during busy, required %h/%h", hi0, lo0);
    end
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL no_second_op: done/busy cycles=%0d, required 0", dones);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, seen; logic got;
    @(negedge clk);
    op = 2'b00; a = 32'd12345; b = 32'd678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0", busy, done, hi, lo);
    end
    @(negedge clk); start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL start_in_reset: busy=%b, required 0", busy);
    end
    @(negedge clk); start = 1'b0; rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL no_done_after_reset: done/busy cycles=%0d, required 0", seen);
    end
    run_op(2'b10, 32'd42, 32'd5, lat, bcnt, got);
    checks++;
    if (!got || lat !== 33 || hi !== 32'd2 || lo !== 32'd8) begin
      errors++; $display("FAIL after_reset_op: got=%b lat=%0d hi=%h lo=%h, required 33 2/8", got, lat, hi, lo);
    end
  endtask

  initial begin
    test_reset;
    test_multu_latency;
    test_signed;
    test_div_edges;
    test_lo_zero;
    test_start_while_busy;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
